// File: rtl/mac_pkg.sv
// Shared types, default widths and saturating arithmetic for the MAC column.
package mac_pkg;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      READY
   } w_state_e;

   localparam int DEF_DEPTH  = 4;
   localparam int DEF_A_W    = 16;
   localparam int DEF_W_W    = 8;
   localparam int DEF_P_W    = 40;
   localparam int DEF_SIGNED = 1;

   // Operands arrive pre-extended to SAT_W so the raw sum never wraps (pw <= 62).
   localparam int SAT_W = 64;

   function automatic logic [SAT_W-1:0] sat_add(input logic [SAT_W-1:0] x,
                                                input logic [SAT_W-1:0] y,
                                                input int pw,
                                                input bit is_signed);
      logic [SAT_W-1:0] sum;
      logic [SAT_W-1:0] hi;
      logic [SAT_W-1:0] lo;
      sum = x + y;
      if (is_signed) begin
         hi = (SAT_W'(1) << (pw - 1)) - SAT_W'(1);
         lo = ~hi;
         if ($signed(sum) > $signed(hi)) begin
            sum = hi;
         end else if ($signed(sum) < $signed(lo)) begin
            sum = lo;
         end
      end else begin
         hi = (SAT_W'(1) << pw) - SAT_W'(1);
         if (sum > hi) begin
            sum = hi;
         end
      end
      return sum;
   endfunction

   function automatic logic sat_ovf(input logic [SAT_W-1:0] x,
                                    input logic [SAT_W-1:0] y,
                                    input int pw,
                                    input bit is_signed);
      return sat_add(x, y, pw, is_signed) != (x + y);
   endfunction

endpackage

// File: rtl/mac_pe.sv
// One column stage: shadow/active weight pair, multiplier, saturating accumulate,
// and the valid/overflow tags that travel alongside the partial sum.
module mac_pe
   import mac_pkg::*;
#(
   parameter int A_W    = DEF_A_W,
   parameter int W_W    = DEF_W_W,
   parameter int P_W    = DEF_P_W,
   parameter int SIGNED = DEF_SIGNED
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           shift_en,
   input  logic           swap_en,
   input  logic [W_W-1:0] w_shift_i,
   output logic [W_W-1:0] w_shift_o,
   input  logic [A_W-1:0] a_i,
   input  logic [P_W-1:0] p_i,
   input  logic           valid_i,
   input  logic           ovf_i,
   output logic [P_W-1:0] p_o,
   output logic           valid_o,
   output logic           ovf_o
);

   localparam int M_W = A_W + W_W;

   logic [W_W-1:0] shadow_q, shadow_d;
   logic [W_W-1:0] active_q, active_d;
   logic [P_W-1:0] psum_q, psum_d;
   logic           valid_q, valid_d;
   logic           ovf_q, ovf_d;
   logic [SAT_W-1:0] prod_x;
   logic [SAT_W-1:0] psum_x;

   if (SIGNED != 0) begin : g_signed
      logic signed [M_W-1:0] a_ext, w_ext, prod;
      assign a_ext  = M_W'($signed(a_i));
      assign w_ext  = M_W'($signed(active_q));
      assign prod   = a_ext * w_ext;
      assign prod_x = SAT_W'(prod);
      assign psum_x = SAT_W'($signed(p_i));
   end else begin : g_unsigned
      logic [M_W-1:0] prod;
      assign prod   = M_W'(a_i) * M_W'(active_q);
      assign prod_x = SAT_W'(prod);
      assign psum_x = SAT_W'(p_i);
   end

   always_comb begin
      shadow_d = shift_en ? w_shift_i : shadow_q;
      // The product above still sees active_q, so a swap takes effect next cycle.
      active_d = swap_en ? shadow_q : active_q;
      psum_d   = P_W'(sat_add(psum_x, prod_x, P_W, SIGNED != 0));
      ovf_d    = ovf_i | sat_ovf(psum_x, prod_x, P_W, SIGNED != 0);
      valid_d  = valid_i;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         shadow_q <= '0;
         active_q <= '0;
         psum_q   <= '0;
         valid_q  <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         shadow_q <= shadow_d;
         active_q <= active_d;
         psum_q   <= psum_d;
         valid_q  <= valid_d;
         ovf_q    <= ovf_d;
      end
   end

   assign w_shift_o = shadow_q;
   assign p_o       = psum_q;
   assign valid_o   = valid_q;
   assign ovf_o     = ovf_q;

endmodule

// File: rtl/mac_column.sv
// Weight-stationary systolic MAC column: serial shadow-weight prefetch FSM,
// DEPTH chained PEs and a registered activation pass-through.
//
// state | meaning
// IDLE  | no load pending; swap requests are rejected
// LOAD  | shifting weight beats into the shadow chain
// READY | full shadow set held; swap allowed
module mac_column
   import mac_pkg::*;
#(
   parameter int DEPTH  = DEF_DEPTH,
   parameter int A_W    = DEF_A_W,
   parameter int W_W    = DEF_W_W,
   parameter int P_W    = DEF_P_W,
   parameter int SIGNED = DEF_SIGNED
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 w_load_start,
   input  logic                 w_valid_i,
   input  logic [W_W-1:0]       w_i,
   output logic                 w_ready,
   output logic                 w_busy,
   input  logic                 w_swap,
   output logic                 swap_err_o,
   input  logic                 conv_valid_i,
   input  logic [DEPTH*A_W-1:0] a_i,
   input  logic [P_W-1:0]       p_i,
   output logic [DEPTH*A_W-1:0] a_o,
   output logic [P_W-1:0]       p_o,
   output logic                 p_valid_o,
   output logic                 ovf_o
);

   localparam int CNT_W = $clog2(DEPTH + 1);

   w_state_e             state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic                 swap_err_q, swap_err_d;
   logic [DEPTH*A_W-1:0] a_q, a_d;
   logic                 shift_en;
   logic                 swap_en;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      shift_en   = 1'b0;
      swap_en    = 1'b0;
      swap_err_d = w_swap && (state_q != READY);
      a_d        = a_i;
      case (state_q)
         IDLE: begin
            if (w_load_start) begin
               state_d = LOAD;
               cnt_d   = '0;
            end
         end
         LOAD: begin
            if (w_valid_i) begin
               shift_en = 1'b1;
               cnt_d    = cnt_q + 1'b1;
               if (cnt_q == CNT_W'(DEPTH - 1)) begin
                  state_d = READY;
               end
            end
         end
         READY: begin
            if (w_swap) begin
               swap_en = 1'b1;
               state_d = IDLE;
            end
            // Swap and load together: commit first, then start the next set.
            if (w_load_start) begin
               state_d = LOAD;
               cnt_d   = '0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         swap_err_q <= 1'b0;
         a_q        <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         swap_err_q <= swap_err_d;
         a_q        <= a_d;
      end
   end

   assign w_ready    = (state_q == READY);
   assign w_busy     = (state_q == LOAD);
   assign swap_err_o = swap_err_q;
   assign a_o        = a_q;

   logic [P_W-1:0] p_chain   [DEPTH+1];
   logic           v_chain   [DEPTH+1];
   logic           ovf_chain [DEPTH+1];
   logic [W_W-1:0] w_chain   [DEPTH+1];

   assign p_chain[0]   = p_i;
   assign v_chain[0]   = conv_valid_i;
   assign ovf_chain[0] = 1'b0;
   assign w_chain[0]   = w_i;

   for (genvar k = 0; k < DEPTH; k++) begin : g_stage
      mac_pe #(
         .A_W    (A_W),
         .W_W    (W_W),
         .P_W    (P_W),
         .SIGNED (SIGNED)
      ) u_pe (
         .clk       (clk),
         .rst       (rst),
         .shift_en  (shift_en),
         .swap_en   (swap_en),
         .w_shift_i (w_chain[k]),
         .w_shift_o (w_chain[k+1]),
         .a_i       (a_i[k*A_W +: A_W]),
         .p_i       (p_chain[k]),
         .valid_i   (v_chain[k]),
         .ovf_i     (ovf_chain[k]),
         .p_o       (p_chain[k+1]),
         .valid_o   (v_chain[k+1]),
         .ovf_o     (ovf_chain[k+1])
      );
   end

   assign p_o       = p_chain[DEPTH];
   assign p_valid_o = v_chain[DEPTH];
   assign ovf_o     = ovf_chain[DEPTH];

endmodule

// File: doc/mac_column.md
Name: mac_column

Overview:
Parametrised weight-stationary systolic column of DEPTH multiply-accumulate stages, the next generation of the single-PE MAC.
- Weights arrive as a serial prefetch stream into per-stage shadow registers, so a new weight set loads while convolution continues on the active set.
- A single-cycle swap commits the shadow set to the active set.
- Partial sums flow down the column with a valid tag and signed saturation. Activations pass through to the neighbouring column.

Parameters:
DEPTH, 4, number of MAC stages (rows) in the column, ≥2
A_W, 16, activation width
W_W, 8, weight width
P_W, 40, partial-sum width
SIGNED, 1, 1 = two's-complement operands, 0 = unsigned

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
w_load_start  in  1  pulse: begin loading a new weight set into the shadow registers
w_valid_i  in  1  w_i beat valid
w_i  in  W_W  weight beat
w_ready  out  1  shadow set complete, swap allowed
w_busy  out  1  load in progress
w_swap  in  1  commit shadow weights to active weights
swap_err_o  out  1  1-cycle pulse: illegal swap request
conv_valid_i  in  1  p_i/a_i sample valid at stage 0
a_i  in  DEPTH*A_W  per-row activations, row r = slice r, externally skewed by r cycles
p_i  in  P_W  incoming partial sum
a_o  out  DEPTH*A_W  a_i registered by 1 cycle, to the next column
p_o  out  P_W  outgoing partial sum
p_valid_o  out  1  p_o valid
ovf_o  out  1  saturation occurred on the sample at p_o

Behaviour:
- Reset (rst=0, asynchronous):
  - All registers clear: active and shadow weights, stage psums, valid pipe, load counter.
  - FSM goes to IDLE.
  - All outputs are 0.
  - Reset mid-load abandons the load; shadow contents are cleared.
- Weight FSM, states IDLE, LOAD, READY:
  - IDLE: w_load_start → LOAD, counter=0.
  - LOAD:
    - Each cycle with w_valid_i=1 shifts w_i into shadow stage 0, and shadow stage k moves to stage k+1.
    - The first beat therefore ends in stage DEPTH-1.
    - counter increments per beat; after beat DEPTH → READY.
    - w_busy=1 throughout LOAD.
  - READY: w_ready=1.
    - w_swap → active[k]=shadow[k] for all k in one cycle, then IDLE.
    - w_load_start → LOAD with counter reset, shadow overwritten.
    - w_swap and w_load_start in the same cycle: perform the swap, then enter LOAD.
- Illegal requests:
  - w_swap in IDLE or LOAD: ignored, swap_err_o pulses 1 cycle, active weights unchanged.
  - w_load_start in LOAD: ignored, counter not restarted.
  - w_valid_i outside LOAD: ignored.
- Compute datapath (every cycle, independent of the FSM):
  - stage0 psum <= sat(p_i + a_i[0]*active[0]).
  - stage k psum <= sat(stage k-1 psum + a_i[k]*active[k]).
  - p_o = stage DEPTH-1 register; latency p_i → p_o is DEPTH cycles.
  - Valid tag: conv_valid_i shifts through a DEPTH-deep pipe; p_valid_o is its output. p_o is meaningful only when p_valid_o=1.
  - Swap in the same cycle as a compute: that cycle uses the old weights, and the new weights apply from the next cycle.
  - In-flight samples straddling a swap mix weight sets; the controller must drain before swapping if this matters. This is not checked.
- Arithmetic:
  - Product width is A_W+W_W, signed or unsigned per SIGNED, then sign- or zero-extended to P_W.
  - Each add saturates to the P_W range: signed [-2^(P_W-1), 2^(P_W-1)-1], unsigned [0, 2^P_W-1].
  - The per-stage saturation flag is ORed down the column alongside the psum; ovf_o is aligned with p_o.
- a_o: registered copy of a_i, 1-cycle latency, not gated by valid.

Decomposition:
- Package mac_pkg holds:
  - the FSM state enum (IDLE, LOAD, READY);
  - default width constants;
  - the saturating-add function, parametrised on SIGNED.
- Sub-module mac_pe, instantiated DEPTH times via generate: shadow/active weight pair, multiplier, saturating adder, psum, valid and ovf registers.
- The top level owns the FSM, the load counter and the a_o registers.

Test Plan:
- Reset: hold rst=0 for 3 cycles → every output 0, w_ready=0; release rst → still IDLE, all outputs 0.
- Load and compute: DEPTH=4, load 3,2,1,4 (giving active 4,1,2,3 for stages 0..3), swap; p_i=1, skewed a=(1,2,3,4), conv_valid_i=1 → 4 cycles later p_o=25, p_valid_o=1, ovf_o=0.
- Overlap: stream with the set from the previous test while loading 1,1,1,1 → outputs stay 25 until the swap; after the swap and drain, the same stimulus gives p_o=11.
- Saturation: SIGNED=1, all w=-128, all a=-32768, p_i=2^39-1 → p_o=2^39-1, ovf_o=1. Then p_i=0, a=0 → ovf_o=0.
- Illegal ops: w_swap in IDLE → swap_err_o=1 for 1 cycle, outputs unchanged. w_load_start at beat 2 of a load → ignored, READY after beat 4.
- Reset mid-load: rst=0 after beat 2 → IDLE, w_busy=0, w_ready=0; a subsequent w_swap raises swap_err_o.
